// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Used by dmem_responder and dmem_array.
package dmem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BE_W       = 4;
    localparam int MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Word index of a byte address, wrapped into the storage depth.
    function automatic logic [MAX_ADDR_W-1:0] word_index(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           depth
    );
        logic [MAX_ADDR_W-1:0] w;
        w = addr >> $clog2(WORD_BYTES);
        return w % MAX_ADDR_W'(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with byte-enable write and registered read.
// Read data is the word content before a same-cycle write.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [BE_W-1:0]  i_be,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Byte-masked write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: request latch, wait states, access, response.
// Define DMEM_ERR_CHECK_EN to flag misaligned/out-of-range requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t r_state;
    state_t w_next;

    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_err;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_err;
    logic [MAX_ADDR_W-1:0] w_addr_ext;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_mem_en;
    logic                  w_mem_we;
    logic [31:0]           w_rdata;

    assign w_req_ready = rst && (r_state == S_IDLE);
    assign w_accept    = req_valid && w_req_ready;
    assign w_addr_ext  = MAX_ADDR_W'(r_addr);
    assign w_idx       = IDX_W'(word_index(w_addr_ext, DEPTH_WORDS));

`ifdef DMEM_ERR_CHECK_EN
    localparam logic [MAX_ADDR_W-1:0] ADDR_LIMIT =
        MAX_ADDR_W'(WORD_BYTES) * MAX_ADDR_W'(DEPTH_WORDS);
    assign w_err = (r_addr[1:0] != 2'b00) || (w_addr_ext >= ADDR_LIMIT);
`else
    assign w_err = 1'b0;
`endif

    // Storage is only touched in ACCESS and never under reset.
    assign w_mem_en = rst && (r_state == S_ACCESS);
    assign w_mem_we = r_we && !w_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_be    (r_be),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Latch the request so later req_* changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Wait counter, error capture and response registers.
    // RESP spends its first cycle capturing the registered array read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_ACCESS: begin
                    r_err <= w_err;
                end
                S_RESP: begin
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= (r_we || r_err) ? '0 : w_rdata;
                        r_rsp_err   <= r_err;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (optionally DMEM_ERR_CHECK_EN).
// Transaction-level memory model plus directed literal checks.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int W     = 2;
    localparam int AW    = 32;
`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          rsp_ready = 1'b1;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference storage with per-byte "has been written" flags.
    logic [31:0] mm [DEPTH];
    logic [3:0]  kb [DEPTH] = '{default: 4'h0};

    // The single outstanding transaction as the model sees it.
    bit          pend = 1'b0;
    int          acc_cyc = 0;
    logic        e_we = 1'b0;
    logic        e_err = 1'b0;
    logic        e_known = 1'b0;
    logic [31:0] e_rdata = '0;
    logic [31:0] e_wdata = '0;
    logic [3:0]  e_be = '0;
    int          e_idx = 0;
    bit          rst_hi_edge = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Model: accept, storage update at the access edge, handshake.
    always @(posedge clk) begin
        logic [31:0] a;
        cyc = cyc + 1;
        rst_hi_edge = rst;
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (pend && cyc == acc_cyc + W + 1 && e_we && !e_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (e_be[b]) begin
                        mm[e_idx][8*b +: 8] = e_wdata[8*b +: 8];
                        kb[e_idx][b] = 1'b1;
                    end
                end
            end
            if (pend && rsp_valid && rsp_ready) begin
                pend = 1'b0;
            end
            if (req_valid && req_ready) begin
                a       = req_addr;
                e_we    = req_we;
                e_wdata = req_wdata;
                e_be    = req_be;
                e_err   = ERR_EN &&
                          ((a % 4) != 0 || a >= 32'(4 * DEPTH));
                e_idx   = int'((a / 4) % DEPTH);
                e_rdata = (req_we || e_err) ? 32'h0 : mm[e_idx];
                e_known = req_we || e_err || (kb[e_idx] == 4'hF);
                acc_cyc = cyc;
                pend    = 1'b1;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            if (!rst_hi_edge) begin
                chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
                chk("rst_rsp_rdata", rsp_rdata, 32'h0);
                chk("rst_rsp_err", 32'(rsp_err), 32'h0);
            end
        end else if (!pend) begin
            chk("idle_req_ready", 32'(req_ready), 32'h1);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        end else begin
            chk("busy_req_ready", 32'(req_ready), 32'h0);
            if (cyc < acc_cyc + W + 2) begin
                chk("early_rsp_valid", 32'(rsp_valid), 32'h0);
            end else begin
                chk("rsp_valid", 32'(rsp_valid), 32'h1);
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
                if (e_known) begin
                    chk("rsp_rdata", rsp_rdata, e_rdata);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output bit ok);
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            if (req_ready) ok = 1'b1;
        end
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        if (!ok) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic er,
                            output int lat);
        bit got;
        got = 1'b0;
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                rd  = rsp_rdata;
                er  = rsp_err;
                lat = cyc - acc_cyc;
            end
        end
        if (!got) begin
            chk("rsp_timeout", 32'h0, 32'h1);
        end else if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        bit ok;
        issue(we, a, wd, be, ok);
        if (ok) begin
            wait_rsp(rd, er, lat);
        end else begin
            rd  = '0;
            er  = 1'b0;
            lat = -1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ok;

        rst       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        repeat (3) begin
            @(posedge clk);
            chk("rst_no_accept", 32'(req_ready), 32'h0);
        end
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        xfer(1'b1, 32'h0, 32'h13579BDF, 4'hF, rd, er, lat);

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("st_latency", 32'(lat), 32'd4);
        chk("st_rdata", rd, 32'h0);
        chk("st_err", 32'(er), 32'h0);

        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("ld_latency", 32'(lat), 32'd4);
        chk("ld_after_st", rd, 32'hDEADBEEF);

        xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("ld_byte_en", rd, 32'hDE22BE44);

        xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        chk("be0_err", 32'(er), 32'h0);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("be0_noop", rd, 32'hDE22BE44);

        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, ok);
        wait_rsp(rd, er, lat);
        chk("bp_latency", 32'(lat), 32'd4);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rdata", rsp_rdata, 32'hDE22BE44);
            chk("bp_err", 32'(rsp_err), 32'h0);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_last_valid", 32'(rsp_valid), 32'h1);
        @(negedge clk);
        chk("bp_done_valid", 32'(rsp_valid), 32'h0);
        chk("bp_done_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;

`ifdef DMEM_ERR_CHECK_EN
        xfer(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
        chk("misalign_err", 32'(er), 32'h1);
        chk("misalign_rdata", rd, 32'h0);
        xfer(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, rd, er, lat);
        chk("oor_st_err", 32'(er), 32'h1);
        chk("oor_st_rdata", rd, 32'h0);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("oor_unchanged", rd, 32'h13579BDF);
        chk("oor_ld0_err", 32'(er), 32'h0);
`else
        xfer(1'b0, 32'(4 * DEPTH + 16), 32'h0, 4'h0, rd, er, lat);
        chk("wrap_rdata", rd, 32'hDE22BE44);
        chk("wrap_err", 32'(er), 32'h0);
        xfer(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
        chk("lowbits_ignored", rd, 32'hDE22BE44);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("ld_word0", rd, 32'h13579BDF);
`endif

        xfer(1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, er, lat);
        issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, ok);
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        xfer(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("abort_old_data", rd, 32'h0BADF00D);

        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, 32'(32'h40 + 4 * i), 32'(32'h10000000 + i * 32'h0101),
                 4'hF, rd, er, lat);
        end
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 32'(32'h40 + 4 * i), 32'h0, 4'h0, rd, er, lat);
            chk("seq_ld", rd, 32'(32'h10000000 + i * 32'h0101));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
